// File: rtl/qpu_dtcm_icb_dma_pkg.sv
// Shared types and constants for the DTCM ICB block mover.
// Width defaults mirror the DTCM controller's address/data widths.
package qpu_dtcm_icb_dma_pkg;

  localparam int QPU_DTCM_ADDR_WIDTH = 16;
  localparam int QPU_DTCM_DATA_WIDTH = 32;
  localparam int QPU_DTCM_LEN_WIDTH  = 8;
  localparam int QPU_DMA_WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FETCH = 3'b001,
    ST_CMD   = 3'b010,
    ST_RSP   = 3'b011,
    ST_DONE  = 3'b100
  } dma_state_t;

  function automatic logic [3:0] cmd_wmask(input logic is_read);
    return is_read ? 4'h0 : 4'hF;
  endfunction

endpackage

// File: rtl/qpu_dtcm_icb_dma_if.sv
// Control, write/read word streams and ICB initiator signals of the block mover.
// master = the mover itself; slave = its environment (controller, streams, DTCM ICB port).
interface qpu_dtcm_icb_dma_if
  import qpu_dtcm_icb_dma_pkg::*;
#(
  parameter int AW   = QPU_DTCM_ADDR_WIDTH,
  parameter int LENW = QPU_DTCM_LEN_WIDTH
) ();

  logic            start;
  logic            start_read;
  logic [AW-1:0]   start_addr;
  logic [LENW-1:0] start_len;
  logic            busy;
  logic            done;

  logic            wr_valid;
  logic            wr_ready;
  logic [31:0]     wr_data;

  logic            rd_valid;
  logic            rd_ready;
  logic [31:0]     rd_data;

  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [31:0]     icb_cmd_wdata;
  logic [3:0]      icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic [31:0]     icb_rsp_rdata;

  modport master (
    input  start, start_read, start_addr, start_len,
    output busy, done,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_cmd_ready,
    input  icb_rsp_valid, icb_rsp_rdata,
    output icb_rsp_ready
  );

  modport slave (
    output start, start_read, start_addr, start_len,
    input  busy, done,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_cmd_ready,
    output icb_rsp_valid, icb_rsp_rdata,
    input  icb_rsp_ready
  );

endinterface

// File: rtl/qpu_dtcm_icb_dma.sv
// Single-outstanding ICB initiator moving a block of words between DTCM and valid/ready streams.
// 3 cycles/word write, 2 cycles/word read; stalls indefinitely on either stream or ICB backpressure.
module qpu_dtcm_icb_dma
  import qpu_dtcm_icb_dma_pkg::*;
#(
  parameter int AW   = QPU_DTCM_ADDR_WIDTH,
  parameter int LENW = QPU_DTCM_LEN_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  qpu_dtcm_icb_dma_if.master bus
);

  dma_state_t      state, state_nxt;
  logic            dir_read;
  logic [AW-1:0]   addr;
  logic [LENW-1:0] cnt;
  logic [31:0]     wdata;

  logic            rsp_hs;
  logic            wr_ready;
  logic            rd_valid;
  logic [31:0]     rd_data;
  logic            cmd_valid;
  logic            rsp_ready;
  logic [3:0]      wmask;

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    wmask     = 4'h0;
    rsp_hs    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.start_len == '0) state_nxt = ST_DONE;
          else if (bus.start_read) state_nxt = ST_CMD;
          else                     state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        cmd_valid = 1'b1;
        wmask     = cmd_wmask(dir_read);
        if (bus.icb_cmd_ready) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        // Read responses flow straight to the stream; only rd_ready gates the ICB ack.
        if (dir_read) begin
          rd_valid  = bus.icb_rsp_valid;
          rd_data   = bus.icb_rsp_rdata;
          rsp_ready = bus.rd_ready;
        end else begin
          rsp_ready = 1'b1;
        end
        rsp_hs = bus.icb_rsp_valid && rsp_ready;
        if (rsp_hs) begin
          if (cnt == LENW'(1)) state_nxt = ST_DONE;
          else if (dir_read)   state_nxt = ST_CMD;
          else                 state_nxt = ST_FETCH;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir_read <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      wdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dir_read <= bus.start_read;
            addr     <= bus.start_addr & ~AW'(3);
            cnt      <= bus.start_len;
          end
        end
        ST_FETCH: if (bus.wr_valid) wdata <= bus.wr_data;
        ST_RSP: begin
          if (rsp_hs) begin
            cnt  <= cnt - LENW'(1);
            addr <= addr + AW'(QPU_DMA_WORD_STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.wr_ready      = wr_ready;
  assign bus.rd_valid      = rd_valid;
  assign bus.rd_data       = rd_data;
  assign bus.icb_cmd_valid = cmd_valid;
  assign bus.icb_cmd_addr  = addr;
  assign bus.icb_cmd_read  = dir_read;
  assign bus.icb_cmd_wdata = wdata;
  assign bus.icb_cmd_wmask = wmask;
  assign bus.icb_rsp_ready = rsp_ready;

endmodule
